dp_sequencer: RTL and testbench
===============================

# dp_sequencer

Micro-op sequencer that drives the register-file/ALU datapath (`datapath`: 4 x 32-bit registers, 2-bit addresses, 3-bit ALU control). It accepts packed micro-ops over a valid/ready port into a small FIFO and issues at most one op per cycle to the datapath's `wr`/`ALUControl`/`addr1..3` inputs. It tracks the datapath's `Zero`/`Overflow` outputs as status flags, supports conditional execution on Zero, and halts on overflow.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `HALT_ON_OVF`, 1: when 1, a sampled `Overflow` on an issued op moves the block to HALT.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `op_valid` in 1: producer has a micro-op.
- `op_data` in 12: micro-op. Fields:
  - [11] cond: execute only if Z flag = 1.
  - [10] wr.
  - [9:7] ALUControl.
  - [6:5] addr1.
  - [4:3] addr2.
  - [2:1] addr3.
  - [0] last.
- `op_ready` out 1: FIFO not full.
- `start` in 1: pulse; IDLE -> RUN.
- `clr` in 1: pulse; HALT -> IDLE, flushes FIFO, clears flags.
- `Zero` in 1: from datapath.
- `Overflow` in 1: from datapath.
- `wr` out 1: to datapath.
- `ALUControl` out 3: to datapath.
- `addr1` out 2: to datapath.
- `addr2` out 2: to datapath.
- `addr3` out 2: to datapath.
- `busy` out 1: state is RUN.
- `done` out 1: one-cycle pulse after a `last` op issues.
- `halted` out 1: state is HALT.
- `flag_z` out 1: Z flag.
- `flag_v` out 1: sticky overflow flag.

## Operation
- States:
  - IDLE: no issue; FIFO accepts pushes.
  - RUN: issues the FIFO head every cycle while the FIFO is non-empty.
  - HALT: no issue, no pops; pushes still accepted while not full.
- Transitions:
  - IDLE -> RUN on `start`.
  - RUN -> IDLE at the edge an op with last=1 pops; `done` = 1 for the following cycle.
  - RUN -> HALT at the edge an issued op samples `Overflow` = 1 with `HALT_ON_OVF` = 1.
  - HALT -> IDLE on `clr`.
  - `start` outside IDLE is ignored. `clr` outside HALT is ignored.
- Issue:
  - In RUN with FIFO non-empty, `ALUControl` and `addr1..3` come combinationally from the head.
  - `wr` = head.wr & (!head.cond | flag_z).
  - The head pops at the rising edge.
  - RUN with FIFO empty: bubble (`wr` = 0), stay in RUN.
- Outputs outside an issue cycle: `wr` = 0, `ALUControl`/`addr*` = 0.
- Flags:
  - Updated only at the pop edge of an executed op (cond satisfied).
  - `flag_z` <= Zero.
  - `flag_v` <= flag_v | Overflow.
  - A skipped conditional op pops without touching the flags.
- Overflow halt: the offending op's write is already committed. The following head is not issued.
- FIFO:
  - Push when `op_valid & op_ready`.
  - `op_ready` = count < DEPTH.
  - Simultaneous push and pop keeps the count; allowed when the FIFO is full only if the pop happens (ready is still 0 when full, so no push).
  - Pointers wrap modulo DEPTH.
- `last` with cond false still ends the program.

## Timing
- Reset (async assert): state IDLE, FIFO empty, `op_ready` = 1, `flag_z` = 0, `flag_v` = 0. All other outputs 0.
- Reset mid-RUN aborts immediately. Queued ops are lost. Any register write not yet clocked is discarded.
- Latency: an op pushed at edge N can issue in cycle N+1 if RUN, so its register write lands at edge N+1. Throughput is 1 op/cycle.
- `start` sampled at edge N: first issue in cycle N+1.
- `done` asserts the cycle after the last pop, for exactly one cycle.
- `busy` deasserts the same cycle.
- `Zero`/`Overflow` are sampled at the same edge that commits `wr`.

## Structure
- Package `dp_seq_pkg`:
  - op field bit positions.
  - op width 12.
  - state encoding (IDLE, RUN, HALT).
  - ALU codes: ADD = 3'b000, SUB = 3'b001.
- Sub-module `op_fifo` (parameterised width/DEPTH; push/pop/full/empty/count, head combinational).
- Top holds the FSM, flags and issue decode.

## Test plan
- Reset then push {ADD, addr1=3, addr2=3, addr3=1, wr=1} and {SUB, 1,1,1, wr=1, last}, then `start`:
  - cycle 1: `wr` = 1, `addr3` = 1, ALUControl = 000.
  - cycle 2: ALUControl = 001.
  - R1 = 0 afterwards, `flag_z` = 1, `done` pulses once, `busy` falls.
- Conditional op: SUB R1-R1 (Z=1), then cond ADD -> `wr` = 1. Then an op giving Z=0, then a cond op -> `wr` = 0, pop occurs, flags unchanged.
- Overflow: R2 = 0x7FFFFFFF, ADD R2+R2 -> `halted` = 1, `flag_v` = 1, next op stays queued. `clr` -> IDLE, FIFO empty, flags 0.
- FIFO full: push 4 ops in IDLE -> `op_ready` = 0 after the 4th. A 5th `op_valid` is not accepted. `start` -> all 4 issue on consecutive cycles.
- Bubble: `start` with the FIFO empty -> `busy` = 1, `wr` = 0. A push then issues on the next cycle.
- Async `rst` low mid-RUN (2 of 4 ops issued) -> outputs 0 immediately, remaining ops not issued after release.

Source files
------------

// File: rtl/dp_seq_pkg.sv
// Shared types and constants for the datapath micro-op sequencer.
package dp_seq_pkg;

   localparam int unsigned OpWidth = 12;

   // Micro-op field bit positions
   localparam int unsigned OpCondBit  = 11;
   localparam int unsigned OpWrBit    = 10;
   localparam int unsigned OpAluMsb   = 9;
   localparam int unsigned OpAluLsb   = 7;
   localparam int unsigned OpAddr1Msb = 6;
   localparam int unsigned OpAddr1Lsb = 5;
   localparam int unsigned OpAddr2Msb = 4;
   localparam int unsigned OpAddr2Lsb = 3;
   localparam int unsigned OpAddr3Msb = 2;
   localparam int unsigned OpAddr3Lsb = 1;
   localparam int unsigned OpLastBit  = 0;

   localparam logic [2:0] AluAdd = 3'b000;
   localparam logic [2:0] AluSub = 3'b001;

   // Field order matches the bit positions above
   typedef struct packed {
      logic       cond;
      logic       wr;
      logic [2:0] alu;
      logic [1:0] addr1;
      logic [1:0] addr2;
      logic [1:0] addr3;
      logic       last;
   } op_t;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StHalt = 2'd2
   } state_e;

   function automatic op_t make_op(logic cond, logic wr, logic [2:0] alu, logic [1:0] a1,
                                   logic [1:0] a2, logic [1:0] a3, logic last);
      op_t o;
      o.cond  = cond;
      o.wr    = wr;
      o.alu   = alu;
      o.addr1 = a1;
      o.addr2 = a2;
      o.addr3 = a3;
      o.last  = last;
      return o;
   endfunction

endpackage

// File: rtl/dp_sequencer_if.sv
// Micro-op producer channel (valid/ready) into the sequencer.
interface dp_sequencer_if;
   import dp_seq_pkg::*;

   logic op_valid;
   op_t  op_data;
   logic op_ready;

   modport master (output op_valid, output op_data, input op_ready);
   modport slave  (input op_valid, input op_data, output op_ready);
endinterface

// File: rtl/op_fifo.sv
// Small synchronous FIFO with combinational head and a synchronous flush.
module op_fifo #(
   parameter int unsigned Width = 12,
   parameter int unsigned Depth = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         flush_i,
   input  logic                         push_i,
   input  logic [Width-1:0]             wdata_i,
   input  logic                         pop_i,
   output logic [Width-1:0]             rdata_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(Depth+1)-1:0]   count_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   // Pointer/count next state; flush drops everything including a same-cycle push
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Depth is a power of two, so pointers wrap naturally
         if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and count registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; empty entries are never issued
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/dp_sequencer.sv
// Micro-op sequencer: queues ops, issues one per cycle to the register-file/ALU
// datapath, tracks Zero/Overflow flags and halts on overflow.
module dp_sequencer
   import dp_seq_pkg::*;
#(
   parameter int unsigned DEPTH       = 4,
   parameter bit          HALT_ON_OVF = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   dp_sequencer_if.slave        op,
   input  logic                 start,
   input  logic                 clr,
   input  logic                 Zero,
   input  logic                 Overflow,
   output logic                 wr,
   output logic [2:0]           ALUControl,
   output logic [1:0]           addr1,
   output logic [1:0]           addr2,
   output logic [1:0]           addr3,
   output logic                 busy,
   output logic                 done,
   output logic                 halted,
   output logic                 flag_z,
   output logic                 flag_v
);

   localparam int unsigned CntW = $clog2(DEPTH + 1);

   state_e          state_q;
   logic            busy_q, done_q, halted_q;
   logic            flag_z_q, flag_v_q;

   logic [OpWidth-1:0] head_raw;
   op_t             head;
   logic            fifo_full, fifo_empty;
   logic [CntW-1:0] fifo_count;
   logic            push, issue, exec, flush;

   assign head  = op_t'(head_raw);
   assign push  = op.op_valid & ~fifo_full;
   assign issue = (state_q == StRun) & ~fifo_empty;
   // A conditional op whose condition fails still issues (pops) but does not execute
   assign exec  = issue & (~head.cond | flag_z_q);
   assign flush = (state_q == StHalt) & clr;

   assign op.op_ready = (fifo_count < CntW'(DEPTH));

   op_fifo #(
      .Width (OpWidth),
      .Depth (DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (rst),
      .flush_i (flush),
      .push_i  (push),
      .wdata_i (op.op_data),
      .pop_i   (issue),
      .rdata_o (head_raw),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // Datapath drive: head fields only during an issue cycle, zero otherwise
   always_comb begin
      wr         = 1'b0;
      ALUControl = '0;
      addr1      = '0;
      addr2      = '0;
      addr3      = '0;
      if (issue) begin
         wr         = exec & head.wr;
         ALUControl = head.alu;
         addr1      = head.addr1;
         addr2      = head.addr2;
         addr3      = head.addr3;
      end
   end

   // Control FSM with registered status outputs and flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         halted_q <= 1'b0;
         flag_z_q <= 1'b0;
         flag_v_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start) begin
                  state_q <= StRun;
                  busy_q  <= 1'b1;
               end
            end
            StRun: begin
               if (issue) begin
                  if (exec) begin
                     flag_z_q <= Zero;
                     flag_v_q <= flag_v_q | Overflow;
                  end
                  // Overflow halt wins over a last op issuing at the same edge
                  if (exec && Overflow && HALT_ON_OVF) begin
                     state_q  <= StHalt;
                     busy_q   <= 1'b0;
                     halted_q <= 1'b1;
                  end else if (head.last) begin
                     state_q <= StIdle;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            StHalt: begin
               if (clr) begin
                  state_q  <= StIdle;
                  halted_q <= 1'b0;
                  flag_z_q <= 1'b0;
                  flag_v_q <= 1'b0;
               end
            end
            default: begin
               state_q  <= StIdle;
               busy_q   <= 1'b0;
               halted_q <= 1'b0;
            end
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign halted = halted_q;
   assign flag_z = flag_z_q;
   assign flag_v = flag_v_q;

endmodule

// File: tb/tb_dp_sequencer.sv
// Self-checking bench for dp_sequencer with a behavioural 4x32 register-file/ALU datapath.
module tb_dp_sequencer;
   import dp_seq_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start, clr;
   logic       Zero, Overflow;
   logic       wr;
   logic [2:0] ALUControl;
   logic [1:0] addr1, addr2, addr3;
   logic       busy, done, halted, flag_z, flag_v;

   always #5 clk = ~clk;

   dp_sequencer_if opif ();

   dp_sequencer #(
      .DEPTH       (4),
      .HALT_ON_OVF (1'b1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .op         (opif),
      .start      (start),
      .clr        (clr),
      .Zero       (Zero),
      .Overflow   (Overflow),
      .wr         (wr),
      .ALUControl (ALUControl),
      .addr1      (addr1),
      .addr2      (addr2),
      .addr3      (addr3),
      .busy       (busy),
      .done       (done),
      .halted     (halted),
      .flag_z     (flag_z),
      .flag_v     (flag_v)
   );

   // Datapath: combinational ALU on rf[addr1], rf[addr2]; write at rising edge
   logic [31:0] rf [4];
   logic [31:0] dp_a, dp_b, dp_res;
   logic        pre_en;
   logic [1:0]  pre_idx;
   logic [31:0] pre_val;

   always_comb begin
      dp_a = rf[addr1];
      dp_b = rf[addr2];
      if (ALUControl == AluSub) begin
         dp_res   = dp_a - dp_b;
         Overflow = (dp_a[31] != dp_b[31]) && (dp_res[31] != dp_a[31]);
      end else begin
         dp_res   = dp_a + dp_b;
         Overflow = (dp_a[31] == dp_b[31]) && (dp_res[31] != dp_a[31]);
      end
      Zero = (dp_res == 32'd0);
   end

   always_ff @(posedge clk) begin
      if (pre_en)  rf[pre_idx] <= pre_val;
      else if (wr) rf[addr3]   <= dp_res;
   end

   // Scoreboard of expected issues
   typedef struct packed {
      logic       wr;
      logic [2:0] alu;
      logic [1:0] a1;
      logic [1:0] a2;
      logic [1:0] a3;
   } iss_t;

   iss_t sb_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Every op in this bench has a non-zero address field, so an issue is always visible
   task automatic mon();
      iss_t got, e;
      got = {wr, ALUControl, addr1, addr2, addr3};
      if (got != '0) begin
         if (sb_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_issue: got 0x%0h, expected no issue", got);
         end else begin
            e = sb_q.pop_front();
            check("issue", 32'(got), 32'(e));
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      mon();
   endtask

   task automatic preload(logic [1:0] idx, logic [31:0] val);
      pre_en  = 1'b1;
      pre_idx = idx;
      pre_val = val;
      cycle();
      pre_en  = 1'b0;
   endtask

   task automatic push(op_t o, bit exp_issue, bit exp_wr);
      iss_t e;
      e = {exp_wr, o.alu, o.addr1, o.addr2, o.addr3};
      if (exp_issue) sb_q.push_back(e);
      opif.op_valid = 1'b1;
      opif.op_data  = o;
      cycle();
      opif.op_valid = 1'b0;
   endtask

   task automatic wait_done(string name, int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         cycle();
         if (done) seen = 1'b1;
      end
      check(name, 32'(seen), 32'd1);
   endtask

   typedef struct {
      op_t         op;
      bit          exp_wr;
      bit          exp_z;
      logic [1:0]  reg_idx;
      logic [31:0] reg_val;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected test completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int nwr;
      start         = 1'b0;
      clr           = 1'b0;
      opif.op_valid = 1'b0;
      opif.op_data  = '0;
      pre_en        = 1'b0;
      pre_idx       = '0;
      pre_val       = '0;

      // Async reset assert before any clock edge
      #1 rst = 1'b0;
      #1;
      check("rst_op_ready", 32'(opif.op_ready), 32'd1);
      check("rst_busy",     32'(busy),   32'd0);
      check("rst_done",     32'(done),   32'd0);
      check("rst_halted",   32'(halted), 32'd0);
      check("rst_flag_z",   32'(flag_z), 32'd0);
      check("rst_flag_v",   32'(flag_v), 32'd0);
      check("rst_dp_bus",   32'({wr, ALUControl, addr1, addr2, addr3}), 32'd0);

      preload(2'd0, 32'd0);
      preload(2'd1, 32'd0);
      preload(2'd2, 32'd0);
      preload(2'd3, 32'd5);
      rst = 1'b1;
      cycle();

      // ---- Basic two-op program ----
      push(make_op(1'b0, 1'b1, AluAdd, 2'd3, 2'd3, 2'd1, 1'b0), 1'b1, 1'b1);
      push(make_op(1'b0, 1'b1, AluSub, 2'd1, 2'd1, 2'd1, 1'b1), 1'b1, 1'b1);
      check("t1_idle_busy", 32'(busy), 32'd0);
      start = 1'b1;
      cycle();
      start = 1'b0;
      check("t1_c1_wr",    32'(wr),         32'd1);
      check("t1_c1_addr3", 32'(addr3),      32'd1);
      check("t1_c1_alu",   32'(ALUControl), 32'd0);
      check("t1_c1_busy",  32'(busy),       32'd1);
      cycle();
      check("t1_c2_alu",   32'(ALUControl), 32'd1);
      check("t1_c2_wr",    32'(wr),         32'd1);
      check("t1_c2_r1",    rf[1],           32'd10);
      check("t1_c2_z",     32'(flag_z),     32'd0);
      cycle();
      check("t1_done",     32'(done),       32'd1);
      check("t1_busy_off", 32'(busy),       32'd0);
      check("t1_flag_z",   32'(flag_z),     32'd1);
      check("t1_r1",       rf[1],           32'd0);
      cycle();
      check("t1_done_once", 32'(done),      32'd0);
      check("t1_sb", 32'(sb_q.size()), 32'd0);

      // ---- Conditional execution, one op per program ----
      vecs[0] = '{make_op(1'b0, 1'b1, AluSub, 2'd1, 2'd1, 2'd1, 1'b1), 1'b1, 1'b1, 2'd1, 32'd0};
      vecs[1] = '{make_op(1'b1, 1'b1, AluAdd, 2'd3, 2'd3, 2'd2, 1'b1), 1'b1, 1'b0, 2'd2, 32'd10};
      vecs[2] = '{make_op(1'b1, 1'b1, AluAdd, 2'd3, 2'd1, 2'd0, 1'b1), 1'b0, 1'b0, 2'd0, 32'd0};
      vecs[3] = '{make_op(1'b0, 1'b1, AluSub, 2'd3, 2'd3, 2'd2, 1'b1), 1'b1, 1'b1, 2'd2, 32'd0};
      vecs[4] = '{make_op(1'b1, 1'b1, AluSub, 2'd3, 2'd2, 2'd1, 1'b1), 1'b1, 1'b0, 2'd1, 32'd5};
      vecs[5] = '{make_op(1'b1, 1'b1, AluAdd, 2'd3, 2'd3, 2'd0, 1'b1), 1'b0, 1'b0, 2'd0, 32'd0};
      for (int i = 0; i < 6; i++) begin
         iss_t e;
         e = {vecs[i].exp_wr, vecs[i].op.alu, vecs[i].op.addr1, vecs[i].op.addr2,
              vecs[i].op.addr3};
         sb_q.push_back(e);
         opif.op_valid = 1'b1;
         opif.op_data  = vecs[i].op;
         start         = 1'b1;
         cycle();
         opif.op_valid = 1'b0;
         start         = 1'b0;
         wait_done($sformatf("t2_v%0d_done", i), 4);
         check($sformatf("t2_v%0d_z", i),   32'(flag_z), 32'(vecs[i].exp_z));
         check($sformatf("t2_v%0d_v", i),   32'(flag_v), 32'd0);
         check($sformatf("t2_v%0d_reg", i), rf[vecs[i].reg_idx], vecs[i].reg_val);
         check($sformatf("t2_v%0d_busy", i), 32'(busy), 32'd0);
      end
      check("t2_sb", 32'(sb_q.size()), 32'd0);

      // ---- Overflow halt, then clr ----
      preload(2'd2, 32'h7FFF_FFFF);
      push(make_op(1'b0, 1'b1, AluAdd, 2'd2, 2'd2, 2'd1, 1'b0), 1'b1, 1'b1);
      push(make_op(1'b0, 1'b1, AluAdd, 2'd3, 2'd3, 2'd0, 1'b1), 1'b0, 1'b0);
      start = 1'b1;
      cycle();
      start = 1'b0;
      check("t3_issue_wr", 32'(wr), 32'd1);
      cycle();
      check("t3_halted",  32'(halted), 32'd1);
      check("t3_flag_v",  32'(flag_v), 32'd1);
      check("t3_flag_z",  32'(flag_z), 32'd0);
      check("t3_busy",    32'(busy),   32'd0);
      check("t3_no_done", 32'(done),   32'd0);
      check("t3_r1",      rf[1],       32'hFFFF_FFFE);
      start = 1'b1;
      cycle();
      start = 1'b0;
      repeat (2) cycle();
      check("t3_start_ignored", 32'(halted), 32'd1);
      check("t3_queued_r0",     rf[0],       32'd0);
      clr = 1'b1;
      cycle();
      clr = 1'b0;
      check("t3_clr_halted", 32'(halted), 32'd0);
      check("t3_clr_v",      32'(flag_v), 32'd0);
      check("t3_clr_z",      32'(flag_z), 32'd0);
      check("t3_clr_busy",   32'(busy),   32'd0);

      // ---- Bubble: run with flushed (empty) FIFO, then a late push ----
      start = 1'b1;
      cycle();
      start = 1'b0;
      check("t4_busy",   32'(busy), 32'd1);
      check("t4_wr",     32'(wr),   32'd0);
      repeat (2) cycle();
      check("t4_busy_hold", 32'(busy), 32'd1);
      push(make_op(1'b0, 1'b1, AluSub, 2'd3, 2'd3, 2'd0, 1'b1), 1'b1, 1'b1);
      check("t4_issue_next", 32'(wr), 32'd1);
      cycle();
      check("t4_done", 32'(done), 32'd1);
      check("t4_idle", 32'(busy), 32'd0);
      check("t4_sb", 32'(sb_q.size()), 32'd0);

      // ---- FIFO full, rejected 5th op, back-to-back issue ----
      push(make_op(1'b0, 1'b1, AluAdd, 2'd3, 2'd3, 2'd1, 1'b0), 1'b1, 1'b1);
      push(make_op(1'b0, 1'b1, AluSub, 2'd3, 2'd3, 2'd2, 1'b0), 1'b1, 1'b1);
      push(make_op(1'b0, 1'b1, AluAdd, 2'd3, 2'd3, 2'd2, 1'b0), 1'b1, 1'b1);
      check("t5_ready_3", 32'(opif.op_ready), 32'd1);
      push(make_op(1'b0, 1'b1, AluSub, 2'd1, 2'd3, 2'd0, 1'b1), 1'b1, 1'b1);
      check("t5_ready_full", 32'(opif.op_ready), 32'd0);
      push(make_op(1'b0, 1'b1, AluAdd, 2'd1, 2'd1, 2'd3, 1'b1), 1'b0, 1'b0);
      check("t5_ready_still", 32'(opif.op_ready), 32'd0);
      start = 1'b1;
      cycle();
      start = 1'b0;
      nwr = wr ? 1 : 0;
      repeat (3) begin
         cycle();
         if (wr) nwr++;
      end
      check("t5_consecutive", 32'(nwr), 32'd4);
      cycle();
      check("t5_done", 32'(done), 32'd1);
      check("t5_r0",   rf[0],     32'd5);
      check("t5_r3",   rf[3],     32'd5);
      start = 1'b1;
      cycle();
      start = 1'b0;
      repeat (3) cycle();
      check("t5_bubble_busy", 32'(busy), 32'd1);
      check("t5_sb", 32'(sb_q.size()), 32'd0);

      // ---- Async reset mid-run ----
      #1 rst = 1'b0;
      cycle();
      rst = 1'b1;
      preload(2'd0, 32'h66);
      preload(2'd1, 32'd0);
      preload(2'd2, 32'h55);
      push(make_op(1'b0, 1'b1, AluAdd, 2'd3, 2'd3, 2'd1, 1'b0), 1'b1, 1'b1);
      push(make_op(1'b0, 1'b1, AluAdd, 2'd3, 2'd3, 2'd2, 1'b0), 1'b1, 1'b1);
      push(make_op(1'b0, 1'b1, AluAdd, 2'd3, 2'd3, 2'd0, 1'b0), 1'b0, 1'b0);
      push(make_op(1'b0, 1'b1, AluSub, 2'd3, 2'd3, 2'd0, 1'b1), 1'b0, 1'b0);
      start = 1'b1;
      cycle();
      start = 1'b0;
      cycle();
      #2 rst = 1'b0;
      #1;
      check("t6_bus_zero",  32'({wr, ALUControl, addr1, addr2, addr3}), 32'd0);
      check("t6_busy",      32'(busy),           32'd0);
      check("t6_op_ready",  32'(opif.op_ready),  32'd1);
      check("t6_r1_commit", rf[1],               32'd10);
      cycle();
      check("t6_r2_discard", rf[2], 32'h55);
      rst = 1'b1;
      start = 1'b1;
      cycle();
      start = 1'b0;
      repeat (4) cycle();
      check("t6_r0_untouched", rf[0], 32'h66);
      check("t6_r2_untouched", rf[2], 32'h55);
      check("t6_busy_bubble",  32'(busy), 32'd1);
      check("t6_sb", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
